// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter needs at least one bit even when WIDTH is 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - one-bit full adder cell
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder driving a single fulladder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic             cout_reg;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

    fulladder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (count == LAST);

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    always_comb begin
        sum_shift            = sum_reg >> 1;
        sum_shift[WIDTH-1]   = fa_sum;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        count   <= '0;
                        sum_reg <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    sum_reg <= sum_shift;
                    carry   <= fa_cout;
                    count   <= count + 1'b1;
                    if (last) begin
                        cout_reg <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction; bp = cycles of held back-pressure, poke = drive junk during RUN.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                           input int bp, input bit poke, input string tag);
        logic [8:0] expv;
        int         n;
        expv = 9'(av) + 9'(bv) + 9'(ci);
        chk({tag, " ready_before"}, 64'(in_ready8), 64'd1);
        a8 = av; b8 = bv; cin8 = ci;
        in_valid8  = 1'b1;
        out_ready8 = (bp == 0);
        step();
        in_valid8 = 1'b0;
        if (poke) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        end
        n = 0;
        while (!out_valid8 && n < 100) begin
            if (poke) chk({tag, " run_ready_low"}, 64'(in_ready8), 64'd0);
            step();
            n++;
        end
        in_valid8 = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'd8);
        chk({tag, " sum"}, 64'(sum8), 64'(expv[7:0]));
        chk({tag, " cout"}, 64'(cout8), 64'(expv[8]));
        for (int i = 0; i < bp; i++) begin
            step();
            chk({tag, " bp_valid"}, 64'(out_valid8), 64'd1);
            chk({tag, " bp_hold"}, 64'({cout8, sum8}), 64'(expv));
        end
        out_ready8 = 1'b1;
        step();
        chk({tag, " back_idle"}, 64'({in_ready8, out_valid8}), 64'b10);
    endtask

    task automatic run_op1(input logic av, input logic bv, input logic ci);
        logic [1:0] expv;
        int         n;
        expv = 2'(av) + 2'(bv) + 2'(ci);
        a1 = av; b1 = bv; cin1 = ci;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        chk("w1 latency", 64'(n), 64'd1);
        chk("w1 result", 64'({cout1, sum1}), 64'(expv));
        step();
        chk("w1 back_idle", 64'({in_ready1, out_valid1}), 64'b10);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        step();
        step();
        chk("rst outputs8", 64'({in_ready8, out_valid8, cout8, sum8}), {53'd0, 11'b10_0_00000000});
        chk("rst outputs1", 64'({in_ready1, out_valid1, cout1, sum1}), 64'b1000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle hold", 64'({in_ready8, out_valid8, cout8, sum8}), {53'd0, 11'b10_0_00000000});
        end

        run_op8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff_plus_1");
        run_op8(8'h5A, 8'h33, 1'b1, 0, 1'b1, "5a_33_c1");
        run_op8(8'h80, 8'h80, 1'b0, 10, 1'b0, "backpressure");

        // Reset during RUN cycle 4.
        a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst running", 64'({in_ready8, out_valid8}), 64'b00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst outputs", 64'({in_ready8, out_valid8, cout8, sum8}), {53'd0, 11'b10_0_00000000});
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst idle", 64'({in_ready8, out_valid8, cout8, sum8}), {53'd0, 11'b10_0_00000000});
        run_op8(8'h01, 8'h01, 1'b0, 0, 1'b0, "after_rst");

        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            run_op1(bits[2], bits[1], bits[0]);
        end

        for (int i = 0; i < 1000; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                    1'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
